tmr_pipelined_control_unit: RTL and testbench
=============================================

// Module: tmr_pipelined_control_unit
// PURPOSE
//  Registered RV32I decode stage: turns Op/funct3/funct7 into the ID/EX control bundle.
//  Replicates decode logic NUM_COPIES times with per-bit majority voting and counts copy mismatches.
//  Adds JAL/JALR/LUI/AUIPC and the full ALU op set to the base control set.
//  Handles pipeline stall/flush. Sits between the IF/ID register and the execute stage.
// PARAMETERS
//  NUM_COPIES  3  decode replicas; legal values 1 (no voting, mismatch tied 0) or 3
//  ALUCTRL_W   4  ALUControl width; must be >=4; codes zero-extended to this width
//  CNT_W       8  fault_count width; counter saturates
// PORTS
//  clk          in   1           clock, rising edge
//  rst          in   1           asynchronous, active-high reset
//  in_valid     in   1           Op/funct3/funct7 hold a valid instruction
//  stall        in   1           hold the current registered bundle
//  flush        in   1           replace the registered bundle with a bubble
//  Op           in   7           instr[6:0]
//  funct3       in   3           instr[14:12]
//  funct7       in   7           instr[31:25]
//  fault_inj    in   NUM_COPIES  bit i inverts every bit of copy i's decoded bundle (verification only)
//  fault_clr    in   1           synchronous clear of fault_count
//  out_valid    out  1           registered bundle is a valid instruction
//  RegWrite     out  1           register-file write enable
//  ALUSrc       out  1           0 = rs2, 1 = immediate
//  MemWrite     out  1           data-memory write enable
//  ResultSrc    out  2           00 ALU, 01 memory, 10 PC+4
//  Branch       out  1           conditional branch
//  Jump         out  1           JAL/JALR
//  JumpReg      out  1           JALR (target = rs1+imm)
//  PCSrcA       out  1           ALU operand A = PC (AUIPC, JAL)
//  ImmSrc       out  3           000 I, 001 S, 010 B, 011 J, 100 U
//  ALUControl   out  ALUCTRL_W   0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sll, 7 srl, 8 sra, 9 sltu, 10 passB
//  illegal      out  1           registered instruction was unrecognised
//  fault_flag   out  1           replicas disagreed on the registered instruction
//  fault_count  out  CNT_W       saturating count of mismatch events
// BEHAVIOUR
//  Reset: every output is 0, fault_count = 0. Reset is asynchronous and takes effect immediately.
//  Latency: exactly one clk. The bundle loaded on edge N is visible after edge N.
//  Load rule, per edge, in priority order:
//   flush -> bubble: out_valid=0, illegal=0, fault_flag=0, and all control fields 0 (flush overrides stall).
//   stall -> all bundle outputs hold their values.
//   in_valid=0 -> bubble.
//   otherwise -> load the voted bundle with out_valid=1.
//  Decode (per copy):
//   lw 0000011: RegWrite, ALUSrc, ResultSrc=01, ImmSrc=I, add.
//   sw 0100011: MemWrite, ALUSrc, ImmSrc=S, add.
//   R 0110011: RegWrite; ALU op from funct3 and funct7[5] (add/sub, sll, slt, sltu, xor, srl/sra, or, and).
//   I 0010011: RegWrite, ALUSrc, ImmSrc=I; same ALU map, except funct7[5] selects only srai. addi is never sub.
//   branch 1100011: Branch, ImmSrc=B, sub.
//   jal 1101111: RegWrite, Jump, PCSrcA, ResultSrc=10, ImmSrc=J, add.
//   jalr 1100111: RegWrite, Jump, JumpReg, ALUSrc, ResultSrc=10, ImmSrc=I, add.
//   lui 0110111: RegWrite, ALUSrc, ImmSrc=U, passB.
//   auipc 0010111: RegWrite, ALUSrc, PCSrcA, ImmSrc=U, add.
//   Any other Op, or an illegal funct7 on R/shift-immediate: all enables 0, illegal=1, out_valid=1.
//  Voting: each output bit is the majority of the three copies (illegal included).
//   mismatch = any copy differs from the voted bundle.
//   fault_flag is registered with the bundle. It obeys the same flush/stall/bubble rules.
//  fault_count: +1 on each load of a valid instruction with mismatch=1. Stalled cycles do not count.
//   Saturates at all-ones. fault_clr wins over a same-cycle increment.
//  One flipped copy: correct bundle and fault_flag=1. Two flipped copies: wrong bundle and fault_flag=1.
// STRUCTURE
//  Shared package ctrl_pkg holds:
//   opcode constants, ImmSrc/ResultSrc/ALUControl codes,
//   the packed bundle typedef ctrl_bundle_t with its width constant.
//  Sub-module ctrl_decode_core: combinational Op/funct3/funct7 -> ctrl_bundle_t.
//   Instantiated NUM_COPIES times via generate.
//  Voter, mismatch detect, pipeline register and counter are inline in this module.
// TESTING
//  1 Reset mid-run: assert rst with stall=1 -> outputs 0 immediately and fault_count=0. Release, apply add -> out_valid=1 next edge.
//  2 Sweep: R add/sub/sra/sltu, addi, srai, lw, sw, beq, jal, jalr, lui, auipc, one per cycle ->
//    registered bundle one edge later matches decode table (e.g. sub: RegWrite=1, ALUControl=1; lui: ALUControl=10, ImmSrc=100).
//  3 Illegal: Op=1111111 -> out_valid=1, illegal=1, RegWrite=MemWrite=Branch=Jump=0.
//  4 Stall then flush: load sw, stall 3 cycles -> MemWrite stays 1. Assert stall and flush together -> bubble, out_valid=0.
//  5 fault_inj=001 on lw -> bundle correct, fault_flag=1, count 0->1.
//    fault_inj=011 -> bundle inverted, fault_flag=1.
//    fault_inj=001 with stall=1 -> count unchanged.
//  6 CNT_W=2: 5 mismatched loads -> count 3 (saturated). fault_clr with a mismatch load in the same cycle -> count 0.

Source files
------------

// File: rtl/tmr_pipelined_control_unit_pkg.sv
// Shared definitions for the TMR decode stage: opcodes, control codes and the
// packed control bundle carried by every decode replica.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLL   = 4'd6;
    localparam logic [3:0] ALU_SRL   = 4'd7;
    localparam logic [3:0] ALU_SRA   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic       branch;
        logic       jump;
        logic       jump_reg;
        logic       pc_src_a;
        logic [2:0] imm_src;
        logic [3:0] alu_ctrl;
        logic       illegal;
    } ctrl_bundle_t;

    localparam int CTRL_W = $bits(ctrl_bundle_t);

    // alt selects sub (funct3=000) or sra (funct3=101); callers gate it for I-type.
    function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/tmr_pipelined_control_unit_decode.sv
// One combinational decode replica: Op/funct3/funct7 to the control bundle.
module ctrl_decode_core
    import ctrl_pkg::*;
(
    input  logic [6:0]   op_i,
    input  logic [2:0]   funct3_i,
    input  logic [6:0]   funct7_i,
    output ctrl_bundle_t bundle_o
);

    logic r_legal;
    logic i_legal;

    // Only add/sub and srl/sra have an alternate funct7 encoding.
    assign r_legal = (funct7_i == 7'b0000000) ||
                     ((funct7_i == 7'b0100000) && (funct3_i == 3'b000 || funct3_i == 3'b101));
    assign i_legal = (funct3_i == 3'b001) ? (funct7_i == 7'b0000000) :
                     (funct3_i == 3'b101) ? (funct7_i == 7'b0000000 || funct7_i == 7'b0100000) :
                     1'b1;

    always_comb begin
        bundle_o = '0;
        case (op_i)
            OP_LOAD: begin
                bundle_o.reg_write  = 1'b1;
                bundle_o.alu_src    = 1'b1;
                bundle_o.result_src = RES_MEM;
                bundle_o.imm_src    = IMM_I;
                bundle_o.alu_ctrl   = ALU_ADD;
            end
            OP_STORE: begin
                bundle_o.mem_write = 1'b1;
                bundle_o.alu_src   = 1'b1;
                bundle_o.imm_src   = IMM_S;
                bundle_o.alu_ctrl  = ALU_ADD;
            end
            OP_R: begin
                if (r_legal) begin
                    bundle_o.reg_write = 1'b1;
                    bundle_o.alu_ctrl  = alu_from_funct(funct3_i, funct7_i[5]);
                end else begin
                    bundle_o.illegal = 1'b1;
                end
            end
            OP_I: begin
                if (i_legal) begin
                    bundle_o.reg_write = 1'b1;
                    bundle_o.alu_src   = 1'b1;
                    bundle_o.imm_src   = IMM_I;
                    bundle_o.alu_ctrl  = alu_from_funct(funct3_i,
                                             (funct3_i == 3'b101) && funct7_i[5]);
                end else begin
                    bundle_o.illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                bundle_o.branch   = 1'b1;
                bundle_o.imm_src  = IMM_B;
                bundle_o.alu_ctrl = ALU_SUB;
            end
            OP_JAL: begin
                bundle_o.reg_write  = 1'b1;
                bundle_o.jump       = 1'b1;
                bundle_o.pc_src_a   = 1'b1;
                bundle_o.result_src = RES_PC4;
                bundle_o.imm_src    = IMM_J;
                bundle_o.alu_ctrl   = ALU_ADD;
            end
            OP_JALR: begin
                bundle_o.reg_write  = 1'b1;
                bundle_o.jump       = 1'b1;
                bundle_o.jump_reg   = 1'b1;
                bundle_o.alu_src    = 1'b1;
                bundle_o.result_src = RES_PC4;
                bundle_o.imm_src    = IMM_I;
                bundle_o.alu_ctrl   = ALU_ADD;
            end
            OP_LUI: begin
                bundle_o.reg_write = 1'b1;
                bundle_o.alu_src   = 1'b1;
                bundle_o.imm_src   = IMM_U;
                bundle_o.alu_ctrl  = ALU_PASSB;
            end
            OP_AUIPC: begin
                bundle_o.reg_write = 1'b1;
                bundle_o.alu_src   = 1'b1;
                bundle_o.pc_src_a  = 1'b1;
                bundle_o.imm_src   = IMM_U;
                bundle_o.alu_ctrl  = ALU_ADD;
            end
            default: bundle_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/tmr_pipelined_control_unit.sv
// Registered RV32I decode stage with replicated decoders, per-bit majority
// voting, replica-mismatch flag and a saturating mismatch counter.
module tmr_pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int NUM_COPIES = 3,
    parameter int ALUCTRL_W  = 4,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [6:0]            Op,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [NUM_COPIES-1:0] fault_inj,
    input  logic                  fault_clr,
    output logic                  out_valid,
    output logic                  RegWrite,
    output logic                  ALUSrc,
    output logic                  MemWrite,
    output logic [1:0]            ResultSrc,
    output logic                  Branch,
    output logic                  Jump,
    output logic                  JumpReg,
    output logic                  PCSrcA,
    output logic [2:0]            ImmSrc,
    output logic [ALUCTRL_W-1:0]  ALUControl,
    output logic                  illegal,
    output logic                  fault_flag,
    output logic [CNT_W-1:0]      fault_count
);

    ctrl_bundle_t      raw   [NUM_COPIES];
    logic [CTRL_W-1:0] copy  [NUM_COPIES];
    logic [CTRL_W-1:0] voted;
    logic              mismatch;

    for (genvar g = 0; g < NUM_COPIES; g++) begin : g_copy
        ctrl_decode_core u_dec (
            .op_i     (Op),
            .funct3_i (funct3),
            .funct7_i (funct7),
            .bundle_o (raw[g])
        );
        assign copy[g] = raw[g] ^ {CTRL_W{fault_inj[g]}};
    end

    if (NUM_COPIES == 3) begin : g_vote
        assign voted    = (copy[0] & copy[1]) | (copy[0] & copy[2]) | (copy[1] & copy[2]);
        assign mismatch = (copy[0] != voted) || (copy[1] != voted) || (copy[2] != voted);
    end else begin : g_single
        assign voted    = copy[0];
        assign mismatch = 1'b0;
    end

    logic             valid_q,  valid_d;
    ctrl_bundle_t     bundle_q, bundle_d;
    logic             flag_q,   flag_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             load_valid;

    // A new instruction is accepted only when neither flush nor stall intervenes.
    assign load_valid = !flush && !stall && in_valid;

    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        flag_d   = flag_q;
        if (flush || (!stall && !in_valid)) begin
            valid_d  = 1'b0;
            bundle_d = '0;
            flag_d   = 1'b0;
        end else if (load_valid) begin
            valid_d  = 1'b1;
            bundle_d = voted;
            flag_d   = mismatch;
        end
    end

    always_comb begin
        count_d = count_q;
        if (fault_clr) begin
            count_d = '0;
        end else if (load_valid && mismatch && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            flag_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            flag_q   <= flag_d;
            count_q  <= count_d;
        end
    end

    assign out_valid   = valid_q;
    assign RegWrite    = bundle_q.reg_write;
    assign ALUSrc      = bundle_q.alu_src;
    assign MemWrite    = bundle_q.mem_write;
    assign ResultSrc   = bundle_q.result_src;
    assign Branch      = bundle_q.branch;
    assign Jump        = bundle_q.jump;
    assign JumpReg     = bundle_q.jump_reg;
    assign PCSrcA      = bundle_q.pc_src_a;
    assign ImmSrc      = bundle_q.imm_src;
    assign ALUControl  = ALUCTRL_W'(bundle_q.alu_ctrl);
    assign illegal     = bundle_q.illegal;
    assign fault_flag  = flag_q;
    assign fault_count = count_q;

endmodule

// File: tb/tb_tmr_pipelined_control_unit.sv
// Bench for tmr_pipelined_control_unit: directed scenarios plus randomized
// traffic, checked every cycle against a table-driven behavioural model.
module tb_tmr_pipelined_control_unit;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RR = 7'b0110011,
                           II = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111,
                           JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

    logic clk = 1'b0;
    logic rst, in_valid, stall, flush, fault_clr;
    logic [6:0] Op, funct7;
    logic [2:0] funct3;
    logic [2:0] fault_inj;

    logic out_valid, RegWrite, ALUSrc, MemWrite, Branch, Jump, JumpReg, PCSrcA, illegal, fault_flag;
    logic [1:0] ResultSrc;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic [7:0] fault_count;

    logic out_valid_s, RegWrite_s, ALUSrc_s, MemWrite_s, Branch_s, Jump_s, JumpReg_s, PCSrcA_s, illegal_s, fault_flag_s;
    logic [1:0] ResultSrc_s;
    logic [2:0] ImmSrc_s;
    logic [3:0] ALUControl_s;
    logic [1:0] fault_count_s;

    always #5 clk = ~clk;

    tmr_pipelined_control_unit #(.NUM_COPIES(3), .ALUCTRL_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .Op(Op), .funct3(funct3), .funct7(funct7), .fault_inj(fault_inj), .fault_clr(fault_clr),
        .out_valid(out_valid), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
        .ResultSrc(ResultSrc), .Branch(Branch), .Jump(Jump), .JumpReg(JumpReg), .PCSrcA(PCSrcA),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal), .fault_flag(fault_flag),
        .fault_count(fault_count)
    );

    tmr_pipelined_control_unit #(.NUM_COPIES(3), .ALUCTRL_W(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .Op(Op), .funct3(funct3), .funct7(funct7), .fault_inj(fault_inj), .fault_clr(fault_clr),
        .out_valid(out_valid_s), .RegWrite(RegWrite_s), .ALUSrc(ALUSrc_s), .MemWrite(MemWrite_s),
        .ResultSrc(ResultSrc_s), .Branch(Branch_s), .Jump(Jump_s), .JumpReg(JumpReg_s), .PCSrcA(PCSrcA_s),
        .ImmSrc(ImmSrc_s), .ALUControl(ALUControl_s), .illegal(illegal_s), .fault_flag(fault_flag_s),
        .fault_count(fault_count_s)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bundle bits: {RegWrite,ALUSrc,MemWrite,ResultSrc,Branch,Jump,JumpReg,PCSrcA,ImmSrc,ALU,illegal}
    function automatic logic [16:0] model_dec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        logic rw, as, mw, br, j, jr, pca, ill;
        logic [1:0] rs;
        logic [2:0] imm;
        logic [3:0] alu;
        logic [3:0] tab [8];
        tab = '{4'd0, 4'd6, 4'd5, 4'd9, 4'd4, 4'd7, 4'd3, 4'd2};
        {rw, as, mw, br, j, jr, pca, ill} = '0;
        rs = 0; imm = 0; alu = 0;
        if (op == LW) begin rw = 1; as = 1; rs = 1; end
        else if (op == SW) begin mw = 1; as = 1; imm = 1; end
        else if (op == RR) begin
            if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
                rw = 1;
                alu = (f7 == 7'h20) ? ((f3 == 0) ? 4'd1 : 4'd8) : tab[f3];
            end else ill = 1;
        end else if (op == II) begin
            if ((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20)) ill = 1;
            else begin
                rw = 1; as = 1;
                alu = (f3 == 5 && f7 == 7'h20) ? 4'd8 : tab[f3];
            end
        end else if (op == BR) begin br = 1; imm = 2; alu = 1; end
        else if (op == JAL) begin rw = 1; j = 1; pca = 1; rs = 2; imm = 3; end
        else if (op == JALR) begin rw = 1; j = 1; jr = 1; as = 1; rs = 2; end
        else if (op == LUI) begin rw = 1; as = 1; imm = 4; alu = 10; end
        else if (op == AUIPC) begin rw = 1; as = 1; pca = 1; imm = 4; end
        else ill = 1;
        return {rw, as, mw, rs, br, j, jr, pca, imm, alu, ill};
    endfunction

    logic        exp_vld, exp_flag, m_mis;
    logic [16:0] exp_ctl, m_dec;
    int          exp_cnt, exp_cnt_s, m_pop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_vld = 0; exp_ctl = 0; exp_flag = 0; exp_cnt = 0; exp_cnt_s = 0;
        end else begin
            m_pop = $countones(fault_inj);
            m_dec = model_dec(Op, funct3, funct7);
            m_mis = (m_pop == 1) || (m_pop == 2);
            if (flush || (!stall && !in_valid)) begin
                exp_vld = 0; exp_ctl = 0; exp_flag = 0;
            end else if (!stall) begin
                exp_vld = 1;
                exp_ctl = (m_pop >= 2) ? ~m_dec : m_dec;
                exp_flag = m_mis;
            end
            if (fault_clr) begin
                exp_cnt = 0; exp_cnt_s = 0;
            end else if (!flush && !stall && in_valid && m_mis) begin
                if (exp_cnt < 255) exp_cnt++;
                if (exp_cnt_s < 3) exp_cnt_s++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("bundle", 32'({out_valid, RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, Jump, JumpReg,
                                 PCSrcA, ImmSrc, ALUControl, illegal, fault_flag}),
                  32'({exp_vld, exp_ctl, exp_flag}));
            check("count", 32'(fault_count), 32'(exp_cnt));
            check("bundle_s", 32'({out_valid_s, RegWrite_s, ALUSrc_s, MemWrite_s, ResultSrc_s, Branch_s, Jump_s,
                                   JumpReg_s, PCSrcA_s, ImmSrc_s, ALUControl_s, illegal_s, fault_flag_s}),
                  32'({exp_vld, exp_ctl, exp_flag}));
            check("count_s", 32'(fault_count_s), 32'(exp_cnt_s));
        end
    end

    task automatic set_in(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        in_valid = v; Op = op; funct3 = f3; funct7 = f7;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] sw_op [13];
    logic [2:0] sw_f3 [13];
    logic [6:0] sw_f7 [13];
    logic [6:0] rop_tab [10];

    initial begin
        sw_op = '{RR, RR, RR, RR, II, II, LW, SW, BR, JAL, JALR, LUI, AUIPC};
        sw_f3 = '{3'd0, 3'd0, 3'd5, 3'd3, 3'd0, 3'd5, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        sw_f7 = '{7'h00, 7'h20, 7'h20, 7'h00, 7'h20, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        rop_tab = '{LW, SW, RR, II, BR, JAL, JALR, LUI, AUIPC, 7'h7F};

        rst = 1; stall = 0; flush = 0; fault_clr = 0; fault_inj = 0;
        set_in(0, 0, 0, 0);
        #1;
        check("reset_valid", 32'(out_valid), 0);
        check("reset_count", 32'(fault_count), 0);
        #12 rst = 0;
        step();

        // Decode sweep, one instruction per cycle
        for (int i = 0; i < 13; i++) begin
            set_in(1, sw_op[i], sw_f3[i], sw_f7[i]);
            step();
            if (i == 1) begin
                check("sub_regwrite", 32'(RegWrite), 1);
                check("sub_aluctrl", 32'(ALUControl), 1);
            end
            if (i == 2) check("sra_aluctrl", 32'(ALUControl), 8);
            if (i == 4) check("addi_not_sub", 32'(ALUControl), 0);
            if (i == 9) check("jal_resultsrc", 32'({ResultSrc, ImmSrc}), 32'({2'b10, 3'b011}));
            if (i == 11) begin
                check("lui_aluctrl", 32'(ALUControl), 10);
                check("lui_immsrc", 32'(ImmSrc), 4);
            end
        end

        // Unrecognised opcode and illegal funct7
        set_in(1, 7'h7F, 0, 0);
        step();
        check("illegal_op", 32'({out_valid, illegal, RegWrite, MemWrite, Branch, Jump}), 32'(6'b110000));
        set_in(1, RR, 3'd1, 7'h20);
        step();
        check("illegal_f7", 32'({out_valid, illegal, RegWrite}), 32'(3'b110));

        // Stall holds a store, then flush beats stall
        set_in(1, SW, 2, 0);
        step();
        stall = 1;
        set_in(1, LW, 2, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold_memwrite", 32'(MemWrite), 1);
        end
        flush = 1;
        step();
        check("flush_bubble", 32'({out_valid, MemWrite}), 0);
        flush = 0; stall = 0;

        // Fault injection
        fault_clr = 1; set_in(0, 0, 0, 0);
        step();
        fault_clr = 0;
        check("clr_count", 32'(fault_count), 0);
        set_in(1, LW, 2, 0); fault_inj = 3'b001;
        step();
        check("inj1_bundle", 32'({RegWrite, ResultSrc, fault_flag}), 32'(4'b1011));
        check("inj1_count", 32'(fault_count), 1);
        fault_inj = 3'b011;
        step();
        check("inj2_inverted", 32'({RegWrite, ALUControl, illegal, fault_flag}), 32'(7'b0111111));
        check("inj2_count", 32'(fault_count), 2);
        fault_inj = 3'b001; stall = 1;
        step();
        check("inj_stall_count", 32'(fault_count), 2);
        stall = 0;

        // Saturation on the narrow counter, then clear beats increment
        fault_clr = 1; fault_inj = 0;
        step();
        fault_clr = 0; fault_inj = 3'b100;
        for (int i = 0; i < 5; i++) step();
        check("sat_count_s", 32'(fault_count_s), 3);
        check("sat_count", 32'(fault_count), 5);
        fault_clr = 1; fault_inj = 3'b001;
        step();
        check("clr_wins", 32'(fault_count), 0);
        check("clr_wins_s", 32'(fault_count_s), 0);
        fault_clr = 0;

        // Asynchronous reset in mid-run while stalled
        step();
        stall = 1; fault_inj = 0;
        #1 rst = 1;
        #1;
        check("async_rst_out", 32'({out_valid, RegWrite, ResultSrc, fault_flag}), 0);
        check("async_rst_count", 32'(fault_count), 0);
        #1 rst = 0;
        stall = 0;
        set_in(1, RR, 0, 0);
        step();
        check("post_rst_valid", 32'({out_valid, RegWrite}), 32'(2'b11));

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 9) != 0);
            stall     = ($urandom_range(0, 5) == 0);
            flush     = ($urandom_range(0, 11) == 0);
            fault_clr = ($urandom_range(0, 40) == 0);
            fault_inj = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'b000;
            Op        = ($urandom_range(0, 9) == 0) ? 7'($urandom) : rop_tab[$urandom_range(0, 9)];
            funct3    = 3'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    funct7 = 7'h00;
                2:       funct7 = 7'h20;
                default: funct7 = 7'($urandom);
            endcase
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
